// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle MIPS main-control FSM with memory wait-state handshake, wait timeout,
// optional bne decode and a sticky trap state for illegal opcodes or bus errors.
module multicycle_ctrl_fsm #(
   parameter int ALUOP_W      = 3,
   parameter int WAIT_TIMEOUT = 15,
   parameter bit HAS_BNE      = 1'b1
) (
   input  logic               clk,
   input  logic               clr,
   input  logic [5:0]         Opcode,
   input  logic               mem_ready,
   output logic               mem_req,
   output logic               IorD,
   output logic               ALUSrcA,
   output logic               IRWrite,
   output logic               PCWrite,
   output logic               Branch,
   output logic               BranchNe,
   output logic               MemWrite,
   output logic               RegWrite,
   output logic               RegDst,
   output logic               MemtoReg,
   output logic [1:0]         PCSrc,
   output logic [1:0]         ALUSrcB,
   output logic [ALUOP_W-1:0] ALUOp,
   output logic               illegal_op,
   output logic               bus_err,
   output logic [3:0]         state_o
);

   // state | meaning: FETCH ir load, DECODE reg read, MEMADR/MEMRD/MEMWB/MEMWR load-store,
   // EXEC/ALUWB r-type, BEQ/BNE branch, *IEX/IMMWB immediates, JUMP, TRAP absorbing error
   typedef enum logic [3:0] {
      FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
      MEMWB  = 4'd4,  MEMWR  = 4'd5,  EXEC   = 4'd6,  ALUWB  = 4'd7,
      BEQ    = 4'd8,  ADDIEX = 4'd9,  IMMWB  = 4'd10, JUMP   = 4'd11,
      ANDIEX = 4'd12, ORIEX  = 4'd13, BNE    = 4'd14, TRAP   = 4'd15
   } state_t;

   localparam int CNT_W = (WAIT_TIMEOUT < 2) ? 1 : $clog2(WAIT_TIMEOUT + 1);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [ALUOP_W-1:0] ALU_ADD = '0;
   localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(1);
   localparam logic [ALUOP_W-1:0] ALU_FUN = ALUOP_W'(2);
   localparam logic [ALUOP_W-1:0] ALU_AND = ALUOP_W'(4);
   localparam logic [ALUOP_W-1:0] ALU_OR  = ALUOP_W'(5);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] wait_cnt;
   logic             stall_st, timeout, set_ill, set_bus;

   assign stall_st = (state == FETCH) || (state == MEMRD) || (state == MEMWR);
   // wait_cnt holds stalls already seen, so this cycle is stall number wait_cnt+1
   assign timeout  = stall_st && !mem_ready && (wait_cnt == CNT_W'(WAIT_TIMEOUT - 1));

   always_comb begin
      state_nxt = state;
      set_ill   = 1'b0;
      set_bus   = 1'b0;
      case (state)
         FETCH:  if (mem_ready) state_nxt = DECODE;
         DECODE: begin
            case (Opcode)
               OP_LW, OP_SW: state_nxt = MEMADR;
               OP_RTYPE:     state_nxt = EXEC;
               OP_BEQ:       state_nxt = BEQ;
               OP_ADDI:      state_nxt = ADDIEX;
               OP_J:         state_nxt = JUMP;
               OP_ANDI:      state_nxt = ANDIEX;
               OP_ORI:       state_nxt = ORIEX;
               OP_BNE: begin
                  if (HAS_BNE) state_nxt = BNE;
                  else begin
                     state_nxt = TRAP;
                     set_ill   = 1'b1;
                  end
               end
               default: begin
                  state_nxt = TRAP;
                  set_ill   = 1'b1;
               end
            endcase
         end
         MEMADR: state_nxt = (Opcode == OP_SW) ? MEMWR : MEMRD;
         MEMRD:  if (mem_ready) state_nxt = MEMWB;
         MEMWR:  if (mem_ready) state_nxt = FETCH;
         EXEC:   state_nxt = ALUWB;
         ADDIEX, ANDIEX, ORIEX: state_nxt = IMMWB;
         MEMWB, ALUWB, IMMWB, BEQ, BNE, JUMP: state_nxt = FETCH;
         TRAP:   state_nxt = TRAP;
         default: state_nxt = TRAP;
      endcase
      if (timeout) begin
         state_nxt = TRAP;
         set_bus   = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state      <= FETCH;
         wait_cnt   <= '0;
         illegal_op <= 1'b0;
         bus_err    <= 1'b0;
      end else begin
         state <= state_nxt;
         if (set_ill) illegal_op <= 1'b1;
         if (set_bus) bus_err    <= 1'b1;
         if (stall_st && !mem_ready && (state_nxt == state)) wait_cnt <= wait_cnt + CNT_W'(1);
         else wait_cnt <= '0;
      end
   end

   always_comb begin
      mem_req  = 1'b0;
      IorD     = 1'b0;
      ALUSrcA  = 1'b0;
      IRWrite  = 1'b0;
      PCWrite  = 1'b0;
      Branch   = 1'b0;
      BranchNe = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
      RegDst   = 1'b0;
      MemtoReg = 1'b0;
      PCSrc    = 2'b00;
      ALUSrcB  = 2'b00;
      ALUOp    = ALU_ADD;
      case (state)
         FETCH: begin
            mem_req = 1'b1;
            ALUSrcB = 2'b01;
            IRWrite = mem_ready;
            PCWrite = mem_ready;
         end
         DECODE: ALUSrcB = 2'b11;
         MEMADR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
         end
         MEMRD: begin
            mem_req = 1'b1;
            IorD    = 1'b1;
         end
         MEMWB: begin
            RegWrite = 1'b1;
            MemtoReg = 1'b1;
         end
         MEMWR: begin
            mem_req  = 1'b1;
            IorD     = 1'b1;
            MemWrite = 1'b1;
         end
         EXEC: begin
            ALUSrcA = 1'b1;
            ALUOp   = ALU_FUN;
         end
         ALUWB: begin
            RegDst   = 1'b1;
            RegWrite = 1'b1;
         end
         BEQ, BNE: begin
            ALUSrcA  = 1'b1;
            ALUOp    = ALU_SUB;
            PCSrc    = 2'b01;
            Branch   = (state == BEQ);
            BranchNe = (state == BNE);
         end
         ADDIEX, ANDIEX, ORIEX: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            ALUOp   = (state == ANDIEX) ? ALU_AND : (state == ORIEX) ? ALU_OR : ALU_ADD;
         end
         IMMWB: RegWrite = 1'b1;
         JUMP: begin
            PCSrc   = 2'b10;
            PCWrite = 1'b1;
         end
         default: ;
      endcase
   end

   assign state_o = state;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench for multicycle_ctrl_fsm: per-cycle vectors driven on the falling edge and
// checked through a scoreboard queue; a second instance covers HAS_BNE=0.
module tb_multicycle_ctrl_fsm;

   // ctrl = {mem_req,IorD,ALUSrcA,IRWrite,PCWrite,Branch,BranchNe,MemWrite,RegWrite,RegDst,MemtoReg,PCSrc,ALUSrcB,ALUOp}
   localparam logic [17:0] C_FETCH   = 18'b1_0_0_0_0_0_0_0_0_0_0_00_01_000;
   localparam logic [17:0] C_FETCH_R = 18'b1_0_0_1_1_0_0_0_0_0_0_00_01_000;
   localparam logic [17:0] C_DEC     = 18'b0_0_0_0_0_0_0_0_0_0_0_00_11_000;
   localparam logic [17:0] C_MADR    = 18'b0_0_1_0_0_0_0_0_0_0_0_00_10_000;
   localparam logic [17:0] C_MRD     = 18'b1_1_0_0_0_0_0_0_0_0_0_00_00_000;
   localparam logic [17:0] C_MWB     = 18'b0_0_0_0_0_0_0_0_1_0_1_00_00_000;
   localparam logic [17:0] C_MWR     = 18'b1_1_0_0_0_0_0_1_0_0_0_00_00_000;
   localparam logic [17:0] C_EXEC    = 18'b0_0_1_0_0_0_0_0_0_0_0_00_00_010;
   localparam logic [17:0] C_ALUWB   = 18'b0_0_0_0_0_0_0_0_1_1_0_00_00_000;
   localparam logic [17:0] C_BEQ     = 18'b0_0_1_0_0_1_0_0_0_0_0_01_00_001;
   localparam logic [17:0] C_BNE     = 18'b0_0_1_0_0_0_1_0_0_0_0_01_00_001;
   localparam logic [17:0] C_ADDI    = 18'b0_0_1_0_0_0_0_0_0_0_0_00_10_000;
   localparam logic [17:0] C_ANDI    = 18'b0_0_1_0_0_0_0_0_0_0_0_00_10_100;
   localparam logic [17:0] C_ORI     = 18'b0_0_1_0_0_0_0_0_0_0_0_00_10_101;
   localparam logic [17:0] C_IMMWB   = 18'b0_0_0_0_0_0_0_0_1_0_0_00_00_000;
   localparam logic [17:0] C_JUMP    = 18'b0_0_0_0_1_0_0_0_0_0_0_10_00_000;
   localparam logic [17:0] C_TRAP    = 18'b0;

   localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, BQ = 6'b000100;
   localparam logic [5:0] BN = 6'b000101, AI = 6'b001000, JJ = 6'b000010, ANI = 6'b001100;
   localparam logic [5:0] ORI = 6'b001101, BAD = 6'b111111;

   typedef struct {
      logic        clr;
      logic [5:0]  op;
      logic        rdy;
      logic [3:0]  st;
      logic [17:0] ctrl;
      logic        ill;
      logic        bus;
      logic        nb_chk;
      logic [3:0]  nb_st;
      logic        nb_ill;
      int          idx;
   } vec_t;

   logic clk = 1'b0;
   logic clr, mem_ready;
   logic [5:0] Opcode;
   logic mem_req, IorD, ALUSrcA, IRWrite, PCWrite, Branch, BranchNe, MemWrite;
   logic RegWrite, RegDst, MemtoReg, illegal_op, bus_err;
   logic [1:0] PCSrc, ALUSrcB;
   logic [2:0] ALUOp;
   logic [3:0] state_o;
   logic nb_mem_req, nb_IorD, nb_ALUSrcA, nb_IRWrite, nb_PCWrite, nb_Branch, nb_BranchNe;
   logic nb_MemWrite, nb_RegWrite, nb_RegDst, nb_MemtoReg, nb_illegal_op, nb_bus_err;
   logic [1:0] nb_PCSrc, nb_ALUSrcB;
   logic [2:0] nb_ALUOp;
   logic [3:0] nb_state_o;
   logic [17:0] ctrl;

   int checks = 0;
   int errors = 0;
   int vec_no = 0;
   vec_t sb[$];
   vec_t tbl[$];

   always #5 clk = ~clk;

   multicycle_ctrl_fsm #(.ALUOP_W(3), .WAIT_TIMEOUT(15), .HAS_BNE(1'b1)) u_dut (
      .clk(clk), .clr(clr), .Opcode(Opcode), .mem_ready(mem_ready), .mem_req(mem_req),
      .IorD(IorD), .ALUSrcA(ALUSrcA), .IRWrite(IRWrite), .PCWrite(PCWrite), .Branch(Branch),
      .BranchNe(BranchNe), .MemWrite(MemWrite), .RegWrite(RegWrite), .RegDst(RegDst),
      .MemtoReg(MemtoReg), .PCSrc(PCSrc), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
      .illegal_op(illegal_op), .bus_err(bus_err), .state_o(state_o));

   multicycle_ctrl_fsm #(.ALUOP_W(3), .WAIT_TIMEOUT(15), .HAS_BNE(1'b0)) u_nobne (
      .clk(clk), .clr(clr), .Opcode(Opcode), .mem_ready(mem_ready), .mem_req(nb_mem_req),
      .IorD(nb_IorD), .ALUSrcA(nb_ALUSrcA), .IRWrite(nb_IRWrite), .PCWrite(nb_PCWrite),
      .Branch(nb_Branch), .BranchNe(nb_BranchNe), .MemWrite(nb_MemWrite),
      .RegWrite(nb_RegWrite), .RegDst(nb_RegDst), .MemtoReg(nb_MemtoReg), .PCSrc(nb_PCSrc),
      .ALUSrcB(nb_ALUSrcB), .ALUOp(nb_ALUOp), .illegal_op(nb_illegal_op),
      .bus_err(nb_bus_err), .state_o(nb_state_o));

   assign ctrl = {mem_req, IorD, ALUSrcA, IRWrite, PCWrite, Branch, BranchNe, MemWrite,
                  RegWrite, RegDst, MemtoReg, PCSrc, ALUSrcB, ALUOp};

   function automatic vec_t v(input logic c, input logic [5:0] o, input logic r,
                              input logic [3:0] s, input logic [17:0] k,
                              input logic il, input logic b);
      vec_t x;
      x.clr = c; x.op = o; x.rdy = r; x.st = s; x.ctrl = k; x.ill = il; x.bus = b;
      x.nb_chk = 1'b0; x.nb_st = 4'd0; x.nb_ill = 1'b0; x.idx = 0;
      return x;
   endfunction

   function automatic vec_t vn(input vec_t x, input logic [3:0] s, input logic il);
      vec_t y;
      y = x;
      y.nb_chk = 1'b1; y.nb_st = s; y.nb_ill = il;
      return y;
   endfunction

   task automatic drive(input vec_t r);
      vec_t x;
      x = r;
      @(negedge clk);
      x.idx = vec_no;
      vec_no++;
      clr = x.clr; Opcode = x.op; mem_ready = x.rdy;
      sb.push_back(x);
   endtask

   // Outputs are compared 2 time units after the falling edge on which inputs changed.
   always @(negedge clk) begin
      vec_t e;
      #2;
      if (sb.size() != 0) begin
         e = sb.pop_front();
         checks++;
         if (state_o !== e.st) begin
            errors++;
            $display("FAIL state vec=%0d got=%0d exp=%0d", e.idx, state_o, e.st);
         end
         checks++;
         if (ctrl !== e.ctrl) begin
            errors++;
            $display("FAIL ctrl vec=%0d got=%b exp=%b", e.idx, ctrl, e.ctrl);
         end
         checks++;
         if (illegal_op !== e.ill) begin
            errors++;
            $display("FAIL illegal_op vec=%0d got=%b exp=%b", e.idx, illegal_op, e.ill);
         end
         checks++;
         if (bus_err !== e.bus) begin
            errors++;
            $display("FAIL bus_err vec=%0d got=%b exp=%b", e.idx, bus_err, e.bus);
         end
         if (e.nb_chk) begin
            checks++;
            if (nb_state_o !== e.nb_st || nb_illegal_op !== e.nb_ill) begin
               errors++;
               $display("FAIL nobne vec=%0d got st=%0d ill=%b exp st=%0d ill=%b",
                        e.idx, nb_state_o, nb_illegal_op, e.nb_st, e.nb_ill);
            end
         end
      end
   end

   initial begin
      // first vector doubles as the reset-state check
      tbl.push_back(v(0, LW, 1, 0, C_FETCH_R, 0, 0));
      tbl.push_back(v(0, LW, 1, 1, C_DEC, 0, 0));
      tbl.push_back(v(0, LW, 1, 2, C_MADR, 0, 0));
      tbl.push_back(v(0, LW, 1, 3, C_MRD, 0, 0));
      tbl.push_back(v(0, LW, 1, 4, C_MWB, 0, 0));
      tbl.push_back(v(0, RT, 1, 0, C_FETCH_R, 0, 0));
      tbl.push_back(v(0, RT, 1, 1, C_DEC, 0, 0));
      tbl.push_back(v(0, BAD, 1, 6, C_EXEC, 0, 0));
      tbl.push_back(v(0, BAD, 1, 7, C_ALUWB, 0, 0));
      tbl.push_back(v(0, AI, 1, 0, C_FETCH_R, 0, 0));
      tbl.push_back(v(0, AI, 1, 1, C_DEC, 0, 0));
      tbl.push_back(v(0, AI, 1, 9, C_ADDI, 0, 0));
      tbl.push_back(v(0, AI, 1, 10, C_IMMWB, 0, 0));
      tbl.push_back(v(0, ANI, 1, 0, C_FETCH_R, 0, 0));
      tbl.push_back(v(0, ANI, 1, 1, C_DEC, 0, 0));
      tbl.push_back(v(0, ANI, 1, 12, C_ANDI, 0, 0));
      tbl.push_back(v(0, ANI, 1, 10, C_IMMWB, 0, 0));
      tbl.push_back(v(0, ORI, 1, 0, C_FETCH_R, 0, 0));
      tbl.push_back(v(0, ORI, 1, 1, C_DEC, 0, 0));
      tbl.push_back(v(0, ORI, 1, 13, C_ORI, 0, 0));
      tbl.push_back(v(0, ORI, 1, 10, C_IMMWB, 0, 0));
      tbl.push_back(v(0, SW, 1, 0, C_FETCH_R, 0, 0));
      tbl.push_back(v(0, SW, 1, 1, C_DEC, 0, 0));
      tbl.push_back(v(0, SW, 1, 2, C_MADR, 0, 0));
      tbl.push_back(v(0, SW, 1, 5, C_MWR, 0, 0));
      tbl.push_back(v(0, BQ, 1, 0, C_FETCH_R, 0, 0));
      tbl.push_back(v(0, BQ, 1, 1, C_DEC, 0, 0));
      tbl.push_back(v(0, BQ, 1, 8, C_BEQ, 0, 0));
      tbl.push_back(v(0, BN, 1, 0, C_FETCH_R, 0, 0));
      tbl.push_back(v(0, BN, 1, 1, C_DEC, 0, 0));
      tbl.push_back(v(0, BN, 1, 14, C_BNE, 0, 0));
      tbl.push_back(v(0, JJ, 0, 0, C_FETCH, 0, 0));
      tbl.push_back(v(0, JJ, 0, 0, C_FETCH, 0, 0));
      tbl.push_back(v(0, JJ, 0, 0, C_FETCH, 0, 0));
      tbl.push_back(v(0, JJ, 1, 0, C_FETCH_R, 0, 0));
      tbl.push_back(v(0, JJ, 1, 1, C_DEC, 0, 0));
      tbl.push_back(v(0, JJ, 1, 11, C_JUMP, 0, 0));
      tbl.push_back(v(0, BAD, 1, 0, C_FETCH_R, 0, 0));
      tbl.push_back(v(0, BAD, 1, 1, C_DEC, 0, 0));
      tbl.push_back(v(0, BAD, 1, 15, C_TRAP, 1, 0));
      tbl.push_back(v(0, LW, 1, 15, C_TRAP, 1, 0));
      tbl.push_back(v(1, LW, 1, 15, C_TRAP, 1, 0));
      tbl.push_back(v(0, LW, 0, 0, C_FETCH, 0, 0));

      clr = 1'b1; Opcode = 6'd0; mem_ready = 1'b0;
      repeat (2) @(posedge clk);
      for (int i = 0; i < tbl.size(); i++) drive(tbl[i]);

      // sw with memory stuck in MEMWR: 15 stalled cycles, then TRAP with bus_err
      drive(v(1, SW, 0, 0, C_FETCH, 0, 0));
      drive(v(0, SW, 1, 0, C_FETCH_R, 0, 0));
      drive(v(0, SW, 1, 1, C_DEC, 0, 0));
      drive(v(0, SW, 1, 2, C_MADR, 0, 0));
      for (int i = 0; i < 15; i++) drive(v(0, SW, 0, 5, C_MWR, 0, 0));
      for (int i = 0; i < 3; i++) drive(v(0, SW, 1, 15, C_TRAP, 0, 1));
      drive(v(1, SW, 0, 15, C_TRAP, 0, 1));
      drive(v(0, SW, 1, 0, C_FETCH_R, 0, 0));

      // ready arrives on the 15th stalled cycle: completes without trap
      drive(v(0, SW, 1, 1, C_DEC, 0, 0));
      drive(v(0, SW, 1, 2, C_MADR, 0, 0));
      for (int i = 0; i < 14; i++) drive(v(0, SW, 0, 5, C_MWR, 0, 0));
      drive(v(0, SW, 1, 5, C_MWR, 0, 0));
      drive(v(0, SW, 1, 0, C_FETCH_R, 0, 0));

      // clr in the middle of a MEMWR stall, then a full 14-stall store
      drive(v(0, SW, 1, 1, C_DEC, 0, 0));
      drive(v(0, SW, 1, 2, C_MADR, 0, 0));
      for (int i = 0; i < 5; i++) drive(v(0, SW, 0, 5, C_MWR, 0, 0));
      drive(v(1, SW, 0, 5, C_MWR, 0, 0));
      drive(v(0, SW, 1, 0, C_FETCH_R, 0, 0));
      drive(v(0, SW, 1, 1, C_DEC, 0, 0));
      drive(v(0, SW, 1, 2, C_MADR, 0, 0));
      for (int i = 0; i < 14; i++) drive(v(0, SW, 0, 5, C_MWR, 0, 0));
      drive(v(0, SW, 1, 5, C_MWR, 0, 0));

      // FETCH timeout
      for (int i = 0; i < 15; i++) drive(v(0, SW, 0, 0, C_FETCH, 0, 0));
      drive(v(0, SW, 0, 15, C_TRAP, 0, 1));

      // bne on both instances after clr
      drive(v(1, BN, 0, 15, C_TRAP, 0, 1));
      drive(vn(v(0, BN, 1, 0, C_FETCH_R, 0, 0), 0, 0));
      drive(vn(v(0, BN, 1, 1, C_DEC, 0, 0), 1, 0));
      drive(vn(v(0, BN, 1, 14, C_BNE, 0, 0), 15, 1));
      drive(vn(v(0, BN, 1, 0, C_FETCH_R, 0, 0), 15, 1));

      repeat (3) @(negedge clk);
      #5;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain got=%0d pending exp=0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
